// File: rtl/cfg_chain.sv
// Config shift chain: WIDTH-bit beats fill a LEN-bit frame; commit copies it to the fabric shadow (CFG_SHADOW_EN).
// Latency: beat visible in shift/cfg_out one cycle after sampling; committed frame on ff_chain one cycle after commit.
// Backpressure: none; beats offered in FULL and early commits are dropped and flagged on sticky err.
module cfg_chain #(
    parameter int LEN   = 8,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic [WIDTH-1:0] cfg_in,
    input  logic             cfg_valid,
    input  logic             commit,
    input  logic             en,
    output logic [LEN-1:0]   ff_chain,
    output logic [WIDTH-1:0] cfg_out,
    output logic             full,
    output logic             cfg_upd,
    output logic             err
);
    localparam int BEATS = LEN / WIDTH;
    localparam int CW    = $clog2(BEATS + 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_SHIFT,
        ST_FULL
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [LEN-1:0]  shift;
    logic [LEN-1:0]  shift_nxt;

    assign shift_nxt = {shift[LEN-WIDTH-1:0], cfg_in};

`ifdef CFG_SHADOW_EN
    logic [LEN-1:0]  shadow;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            shadow <= '0;
        end else if (state == ST_FULL && commit) begin
            shadow <= shift;
        end
    end

    assign ff_chain = en ? shadow : '0;
`else
    // Transparent mode: the fabric sees the chain as it shifts.
    assign ff_chain = en ? shift : '0;
`endif

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state   <= ST_EMPTY;
            cnt     <= '0;
            shift   <= '0;
            cfg_upd <= 1'b0;
            err     <= 1'b0;
        end else begin
            cfg_upd <= 1'b0;
            case (state)
                ST_EMPTY: begin
                    if (cfg_valid) begin
                        shift <= shift_nxt;
                        cnt   <= CW'(1);
                        state <= (BEATS == 1) ? ST_FULL : ST_SHIFT;
                    end
                    if (commit) begin
                        err <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cfg_valid) begin
                        shift <= shift_nxt;
                        cnt   <= cnt + CW'(1);
                        if (cnt + CW'(1) == CW'(BEATS)) begin
                            state <= ST_FULL;
                        end
                    end
                    if (commit) begin
                        err <= 1'b1;
                    end
                end
                ST_FULL: begin
                    // A beat offered here has nowhere to go; flag it rather than lose it silently.
                    if (cfg_valid) begin
                        err <= 1'b1;
                    end
                    if (commit) begin
                        cnt     <= '0;
                        cfg_upd <= 1'b1;
                        state   <= ST_EMPTY;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign full    = (state == ST_FULL);
    assign cfg_out = shift[LEN-1 -: WIDTH];
endmodule

// File: tb/tb_cfg_chain.sv
// Table-driven bench for cfg_chain at LEN=8, WIDTH=2; expectations hold with or without CFG_SHADOW_EN.
module tb_cfg_chain;
    logic       clk = 1'b0;
    logic       res_n;
    logic [1:0] cfg_in;
    logic       cfg_valid;
    logic       commit;
    logic       en;
    logic [7:0] ff_chain;
    logic [1:0] cfg_out;
    logic       full;
    logic       cfg_upd;
    logic       err;

    int errors = 0;
    int checks = 0;

    cfg_chain #(.LEN(8), .WIDTH(2)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .cfg_in    (cfg_in),
        .cfg_valid (cfg_valid),
        .commit    (commit),
        .en        (en),
        .ff_chain  (ff_chain),
        .cfg_out   (cfg_out),
        .full      (full),
        .cfg_upd   (cfg_upd),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       v;
        logic [1:0] d;
        logic       c;
        logic       e;
        logic [7:0] x_shift;
        logic [7:0] x_shadow;
        logic       x_full;
        logic       x_upd;
        logic       x_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic [1:0] d, input logic c,
                       input logic e, input logic [7:0] sh, input logic [7:0] sd,
                       input logic f, input logic u, input logic er);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.c = c; t.e = e;
        t.x_shift = sh; t.x_shadow = sd; t.x_full = f; t.x_upd = u; t.x_err = er;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_ff(input logic e, input logic [7:0] sh, input logic [7:0] sd);
`ifdef CFG_SHADOW_EN
        return e ? sd : 8'h00;
`else
        return e ? sh : 8'h00;
`endif
    endfunction

    task automatic load4(input logic [7:0] sd, input logic er);
        add(1, 1, 2'b10, 0, 1, 8'h02, sd, 0, 0, er);
        add(1, 1, 2'b11, 0, 1, 8'h0B, sd, 0, 0, er);
        add(1, 1, 2'b00, 0, 1, 8'h2C, sd, 0, 0, er);
        add(1, 1, 2'b01, 0, 1, 8'hB1, sd, 1, 0, er);
    endtask

    initial begin
        logic [7:0] sh_last;
        logic [7:0] sd_last;
        // reset with busy inputs
        add(0, 1, 2'b11, 1, 1, 8'h00, 8'h00, 0, 0, 0);
        add(0, 1, 2'b01, 1, 0, 8'h00, 8'h00, 0, 0, 0);
        // full load and commit, then output enable gating
        load4(8'h00, 0);
        add(1, 0, 2'b00, 1, 1, 8'hB1, 8'hB1, 0, 1, 0);
        add(1, 0, 2'b00, 0, 1, 8'hB1, 8'hB1, 0, 0, 0);
        add(1, 0, 2'b00, 0, 0, 8'hB1, 8'hB1, 0, 0, 0);
        // early commit
        add(0, 0, 2'b00, 0, 1, 8'h00, 8'h00, 0, 0, 0);
        add(1, 1, 2'b10, 0, 1, 8'h02, 8'h00, 0, 0, 0);
        add(1, 1, 2'b11, 0, 1, 8'h0B, 8'h00, 0, 0, 0);
        add(1, 0, 2'b00, 1, 1, 8'h0B, 8'h00, 0, 0, 1);
        add(1, 1, 2'b00, 0, 1, 8'h2C, 8'h00, 0, 0, 1);
        add(1, 1, 2'b01, 0, 1, 8'hB1, 8'h00, 1, 0, 1);
        add(1, 0, 2'b00, 1, 1, 8'hB1, 8'hB1, 0, 1, 1);
        // overflow, commit+beat in FULL, back-to-back beat after commit
        add(0, 0, 2'b00, 0, 1, 8'h00, 8'h00, 0, 0, 0);
        load4(8'h00, 0);
        add(1, 1, 2'b11, 0, 1, 8'hB1, 8'h00, 1, 0, 1);
        add(1, 1, 2'b11, 1, 1, 8'hB1, 8'hB1, 0, 1, 1);
        add(1, 1, 2'b10, 0, 1, 8'hC6, 8'hB1, 0, 0, 1);
        // beat+commit while shifting: beat taken, commit flagged
        add(0, 0, 2'b00, 0, 1, 8'h00, 8'h00, 0, 0, 0);
        add(1, 1, 2'b10, 0, 1, 8'h02, 8'h00, 0, 0, 0);
        add(1, 1, 2'b11, 1, 1, 8'h0B, 8'h00, 0, 0, 1);
        // reset mid-frame discards partial frame and shadow
        add(0, 0, 2'b00, 0, 1, 8'h00, 8'h00, 0, 0, 0);
        load4(8'h00, 0);
        add(1, 0, 2'b00, 1, 1, 8'hB1, 8'hB1, 0, 1, 0);
        add(1, 1, 2'b10, 0, 1, 8'hC6, 8'hB1, 0, 0, 0);
        add(1, 1, 2'b11, 0, 1, 8'h1B, 8'hB1, 0, 0, 0);
        add(0, 0, 2'b00, 0, 1, 8'h00, 8'h00, 0, 0, 0);
        load4(8'h00, 0);
        add(1, 0, 2'b00, 1, 1, 8'hB1, 8'hB1, 0, 1, 0);
        // commit in EMPTY
        add(1, 0, 2'b00, 1, 1, 8'hB1, 8'hB1, 0, 0, 1);

        res_n = 1'b0; cfg_in = 2'b00; cfg_valid = 1'b0; commit = 1'b0; en = 1'b0;
        @(posedge clk); #1;
        sh_last = 8'h00; sd_last = 8'h00;
        for (int i = 0; i < vecs.size(); i++) begin
            res_n = vecs[i].r; cfg_valid = vecs[i].v; cfg_in = vecs[i].d;
            commit = vecs[i].c; en = vecs[i].e;
            @(posedge clk); #1;
            chk("ff_chain", i, ff_chain, exp_ff(vecs[i].e, vecs[i].x_shift, vecs[i].x_shadow));
            chk("cfg_out", i, {6'b0, cfg_out}, {6'b0, vecs[i].x_shift[7:6]});
            chk("full", i, {7'b0, full}, {7'b0, vecs[i].x_full});
            chk("cfg_upd", i, {7'b0, cfg_upd}, {7'b0, vecs[i].x_upd});
            chk("err", i, {7'b0, err}, {7'b0, vecs[i].x_err});
            sh_last = vecs[i].x_shift; sd_last = vecs[i].x_shadow;
        end

        // en gates ff_chain combinationally, between clock edges
        cfg_valid = 1'b0; commit = 1'b0;
        en = 1'b0; #1;
        chk("en_low_comb", -1, ff_chain, 8'h00);
        en = 1'b1; #1;
        chk("en_high_comb", -1, ff_chain, exp_ff(1'b1, sh_last, sd_last));
        // idle cycles hold state and err stays sticky
        repeat (3) @(posedge clk);
        #1;
        chk("hold_ff", -1, ff_chain, exp_ff(1'b1, sh_last, sd_last));
        chk("hold_err", -1, {7'b0, err}, 8'h01);
        chk("hold_upd", -1, {7'b0, cfg_upd}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
